// File: rtl/fofb_coef_pkg.sv
// Shared definitions for the FOFB coefficient write engine: GPIO command codes,
// write-destination codes, status bit positions and small elaboration helpers.
package fofb_coef_pkg;

    localparam int CHUNK_W  = 16;
    localparam int TARGET_W = 3;

    typedef enum logic [3:0] {
        CMD_LATCH_ADDRESS   = 4'h1,
        CMD_LATCH_CHUNK     = 4'h2,
        CMD_WRITE_MATRIX    = 4'h3,
        CMD_WRITE_GAIN      = 4'h4,
        CMD_WRITE_FFB_CLIP  = 4'h5,
        CMD_WRITE_PS_OFFSET = 4'h6,
        CMD_WRITE_PS_CLIP   = 4'h7,
        CMD_FIR_RELOAD      = 4'h8,
        CMD_FIR_CONFIG      = 4'h9,
        CMD_CLEAR_STATUS    = 4'hA
    } cmd_e;

    typedef enum logic [TARGET_W-1:0] {
        TGT_MATRIX     = 3'd0,
        TGT_GAIN       = 3'd1,
        TGT_FFB_CLIP   = 3'd2,
        TGT_PS_OFFSET  = 3'd3,
        TGT_PS_CLIP    = 3'd4,
        TGT_FIR_RELOAD = 3'd5,
        TGT_FIR_CONFIG = 3'd6
    } target_e;

    typedef struct packed {
        logic    is_write;
        target_e target;
    } write_decode_t;

    localparam int ST_DROP_LSB = 0;
    localparam int ST_OVERFLOW = 8;
    localparam int ST_ADDR_ERR = 9;
    localparam int ST_EMPTY    = 10;
    localparam int ST_FULL     = 11;
    localparam int ST_OCC_LSB  = 12;
    localparam int ST_AUTOINC  = 16;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic write_decode_t decode_write(input cmd_e cmd);
        write_decode_t d;
        d.is_write = 1'b1;
        d.target   = TGT_MATRIX;
        case (cmd)
            CMD_WRITE_MATRIX:    d.target = TGT_MATRIX;
            CMD_WRITE_GAIN:      d.target = TGT_GAIN;
            CMD_WRITE_FFB_CLIP:  d.target = TGT_FFB_CLIP;
            CMD_WRITE_PS_OFFSET: d.target = TGT_PS_OFFSET;
            CMD_WRITE_PS_CLIP:   d.target = TGT_PS_CLIP;
            CMD_FIR_RELOAD:      d.target = TGT_FIR_RELOAD;
            CMD_FIR_CONFIG:      d.target = TGT_FIR_CONFIG;
            default:             d.is_write = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fofb_cmd_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head word is
// visible on o_data whenever o_empty is low. DEPTH must be a power of two.
module fofb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // NOTE: storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/fofb_coef_write_engine.sv
// Decodes strobed GPIO commands into addressed coefficient/config writes and queues
// them on a valid/ready port, with address auto-increment and drop accounting.
module fofb_coef_write_engine
    import fofb_coef_pkg::*;
#(
    parameter int RESULT_COUNT      = 32,
    parameter int PLANE_COUNT       = 2,
    parameter int MATRIX_ADDR_WIDTH = 9,
    parameter int COEFFICIENT_WIDTH = 32,
    parameter int CMD_SHIFT         = 28,
    parameter int FIFO_DEPTH        = 4,
    localparam int ROW_W   = clog2_min1(RESULT_COUNT),
    localparam int PLANE_W = clog2_min1(PLANE_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         csrStrobe,
    input  logic [31:0]                  GPIO_OUT,
    output logic [31:0]                  status,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [2:0]                   wr_target,
    output logic [ROW_W-1:0]             wr_row,
    output logic [PLANE_W-1:0]           wr_plane,
    output logic [MATRIX_ADDR_WIDTH-1:0] wr_column,
    output logic [COEFFICIENT_WIDTH-1:0] wr_data
);

    localparam int CHUNKS    = COEFFICIENT_WIDTH / CHUNK_W;
    // Plane and row fields are one bit wider than stored so out-of-range values are detectable.
    localparam int PLANE_FW  = PLANE_W + 1;
    localparam int ROW_FW    = ROW_W + 1;
    localparam int PLANE_LSB = MATRIX_ADDR_WIDTH;
    localparam int ROW_LSB   = PLANE_LSB + PLANE_FW;
    localparam int ENTRY_W   = TARGET_W + ROW_W + PLANE_W + MATRIX_ADDR_WIDTH + COEFFICIENT_WIDTH;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [ROW_W-1:0]             r_row;
    logic [PLANE_W-1:0]           r_plane;
    logic [MATRIX_ADDR_WIDTH-1:0] r_column;
    logic                         r_autoinc;
    logic [7:0]                   r_drop_count;
    logic                         r_overflow;
    logic                         r_addr_err;

    cmd_e                         w_cmd;
    write_decode_t                w_dec;
    logic [MATRIX_ADDR_WIDTH-1:0] w_lat_column;
    logic [PLANE_FW-1:0]          w_lat_plane;
    logic [ROW_FW-1:0]            w_lat_row;
    logic                         w_addr_ok;
    logic                         w_pop;
    logic                         w_push_req;
    logic                         w_push_accept;
    logic                         w_push_drop;
    logic                         w_advance;
    logic [COEFFICIENT_WIDTH-1:0] w_data;
    logic [ENTRY_W-1:0]           w_push_entry;
    logic [ENTRY_W-1:0]           w_head;
    logic [2:0]                   w_head_target;
    logic                         w_empty;
    logic                         w_full;
    logic [CNT_W-1:0]             w_count;
    logic                         w_unused_gpio;

    assign w_cmd         = cmd_e'(GPIO_OUT[CMD_SHIFT +: 4]);
    assign w_dec         = decode_write(w_cmd);
    assign w_lat_column  = GPIO_OUT[0 +: MATRIX_ADDR_WIDTH];
    assign w_lat_plane   = GPIO_OUT[PLANE_LSB +: PLANE_FW];
    assign w_lat_row     = GPIO_OUT[ROW_LSB +: ROW_FW];
    assign w_addr_ok     = (w_lat_plane < PLANE_FW'(PLANE_COUNT)) && (w_lat_row < ROW_FW'(RESULT_COUNT));
    assign w_unused_gpio = ^GPIO_OUT;

    assign w_pop         = wr_valid && wr_ready;
    assign w_push_req    = csrStrobe && w_dec.is_write;
    assign w_push_accept = w_push_req && (!w_full || w_pop);
    assign w_push_drop   = w_push_req && w_full && !w_pop;
    assign w_advance     = w_push_accept && (w_dec.target == TGT_MATRIX) && r_autoinc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_plane      <= '0;
            r_column     <= '0;
            r_autoinc    <= 1'b0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (csrStrobe) begin
                case (w_cmd)
                    CMD_LATCH_ADDRESS: begin
                        if (w_addr_ok) begin
                            r_column  <= w_lat_column;
                            r_plane   <= w_lat_plane[PLANE_W-1:0];
                            r_row     <= w_lat_row[ROW_W-1:0];
                            r_autoinc <= GPIO_OUT[CMD_SHIFT-1];
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end
                    CMD_CLEAR_STATUS: begin
                        r_drop_count <= '0;
                        r_overflow   <= 1'b0;
                        r_addr_err   <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Column, then plane, then row form a carry chain, each wrapping at its own limit.
            if (w_advance) begin
                r_column <= r_column + MATRIX_ADDR_WIDTH'(1);
                if (&r_column) begin
                    if (r_plane == PLANE_W'(PLANE_COUNT - 1)) begin
                        r_plane <= '0;
                        r_row   <= (r_row == ROW_W'(RESULT_COUNT - 1)) ? '0 : r_row + ROW_W'(1);
                    end else begin
                        r_plane <= r_plane + PLANE_W'(1);
                    end
                end
            end

            if (w_push_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    // The upper chunks persist across pushes so consecutive writes can share them.
    generate
        if (CHUNKS > 1) begin : g_chunk_reg
            localparam int CHUNK_REG_W = (CHUNKS - 1) * CHUNK_W;
            logic [CHUNK_REG_W-1:0] r_chunks;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_chunks <= '0;
                end else if (csrStrobe && (w_cmd == CMD_LATCH_CHUNK)) begin
                    r_chunks <= (r_chunks << CHUNK_W) | CHUNK_REG_W'(GPIO_OUT[CHUNK_W-1:0]);
                end
            end

            assign w_data = {r_chunks, GPIO_OUT[CHUNK_W-1:0]};
        end else begin : g_no_chunk_reg
            assign w_data = GPIO_OUT[CHUNK_W-1:0];
        end
    endgenerate

    assign w_push_entry = {w_dec.target, r_row, r_plane, r_column, w_data};

    fofb_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_accept),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign {w_head_target, wr_row, wr_plane, wr_column, wr_data} = w_head;
    assign wr_target = w_head_target;
    assign wr_valid  = !w_empty;

    // NOTE: every bit gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        status                       = '0;
        status[ST_DROP_LSB +: 8]     = r_drop_count;
        status[ST_OVERFLOW]          = r_overflow;
        status[ST_ADDR_ERR]          = r_addr_err;
        status[ST_EMPTY]             = w_empty;
        status[ST_FULL]              = w_full;
        status[ST_OCC_LSB +: 4]      = (int'(w_count) > 15) ? 4'hF : 4'(w_count);
        status[ST_AUTOINC]           = r_autoinc;
    end

endmodule

// File: tb/tb_fofb_coef_write_engine.sv
// Bench for fofb_coef_write_engine at default parameters: table vectors, targeted
// corner sequences and random traffic against a queue-based reference model.
module tb_fofb_coef_write_engine;
    import fofb_coef_pkg::*;

    localparam int N_ROWS   = 32;
    localparam int N_PLANES = 2;
    localparam int N_COLS   = 512;
    localparam int QDEPTH   = 4;
    localparam int ADDR_SPACE = N_ROWS * N_PLANES * N_COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csrStrobe = 1'b0;
    logic [31:0] GPIO_OUT = '0;
    logic        wr_ready = 1'b0;
    logic [31:0] status;
    logic        wr_valid;
    logic [2:0]  wr_target;
    logic [4:0]  wr_row;
    logic [0:0]  wr_plane;
    logic [8:0]  wr_column;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fofb_coef_write_engine dut (
        .clk       (clk),
        .rst       (rst),
        .csrStrobe (csrStrobe),
        .GPIO_OUT  (GPIO_OUT),
        .status    (status),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_target (wr_target),
        .wr_row    (wr_row),
        .wr_plane  (wr_plane),
        .wr_column (wr_column),
        .wr_data   (wr_data)
    );

    // Reference model: one linear address (row-major over row, plane, column) and a queue.
    typedef struct {
        int          tgt;
        int          row;
        int          plane;
        int          col;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    int          m_idx;
    bit          m_ai;
    int          m_drop;
    bit          m_ovf;
    bit          m_aerr;
    logic [15:0] m_hi;

    task automatic model_reset();
        m_q.delete();
        m_idx = 0; m_ai = 0; m_drop = 0; m_ovf = 0; m_aerr = 0; m_hi = '0;
    endtask

    task automatic model_step(input bit s, input logic [31:0] g, input bit r);
        logic [3:0] cmd;
        bit   pop;
        bit   is_wr;
        int   tgt;
        int   col, pl, rw;
        ent_t e;
        cmd   = g[31:28];
        pop   = r && (m_q.size() != 0);
        is_wr = 1'b1;
        tgt   = 0;
        case (cmd)
            4'h3: tgt = 0;
            4'h4: tgt = 1;
            4'h5: tgt = 2;
            4'h6: tgt = 3;
            4'h7: tgt = 4;
            4'h8: tgt = 5;
            4'h9: tgt = 6;
            default: is_wr = 1'b0;
        endcase
        if (!s) is_wr = 1'b0;
        if (s && cmd == 4'h1) begin
            col = int'(g[8:0]);
            pl  = int'(g[10:9]);
            rw  = int'(g[16:11]);
            if (pl >= N_PLANES || rw >= N_ROWS) begin
                m_aerr = 1;
            end else begin
                m_idx = (rw * N_PLANES + pl) * N_COLS + col;
                m_ai  = g[27];
            end
        end
        if (s && cmd == 4'h2) m_hi = g[15:0];
        if (s && cmd == 4'hA) begin
            m_drop = 0; m_ovf = 0; m_aerr = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (is_wr) begin
            if (m_q.size() < QDEPTH) begin
                e.tgt   = tgt;
                e.col   = m_idx % N_COLS;
                e.plane = (m_idx / N_COLS) % N_PLANES;
                e.row   = m_idx / (N_COLS * N_PLANES);
                e.data  = {m_hi, g[15:0]};
                m_q.push_back(e);
                if (tgt == 0 && m_ai) m_idx = (m_idx + 1) % ADDR_SPACE;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int occ;
        s   = '0;
        occ = m_q.size();
        if (occ > 15) occ = 15;
        s[7:0]   = m_drop[7:0];
        s[8]     = m_ovf;
        s[9]     = m_aerr;
        s[10]    = (m_q.size() == 0);
        s[11]    = (m_q.size() == QDEPTH);
        s[15:12] = occ[3:0];
        s[16]    = m_ai;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " status"}, 64'(status), 64'(m_status()));
        check({tag, " valid"}, 64'(wr_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check({tag, " target"}, 64'(wr_target), 64'(m_q[0].tgt));
            check({tag, " row"},    64'(wr_row),    64'(m_q[0].row));
            check({tag, " plane"},  64'(wr_plane),  64'(m_q[0].plane));
            check({tag, " column"}, 64'(wr_column), 64'(m_q[0].col));
            check({tag, " data"},   64'(wr_data),   64'(m_q[0].data));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input bit s, input logic [31:0] g, input bit r);
        csrStrobe = s;
        GPIO_OUT  = g;
        wr_ready  = r;
        @(posedge clk);
        model_step(s, g, r);
        @(negedge clk);
    endtask

    function automatic logic [31:0] addr_word(input int row, input int pl, input int col, input bit ai);
        logic [31:0] w;
        w        = '0;
        w[31:28] = CMD_LATCH_ADDRESS;
        w[27]    = ai;
        w[16:11] = row[5:0];
        w[10:9]  = pl[1:0];
        w[8:0]   = col[8:0];
        return w;
    endfunction

    function automatic logic [31:0] cmd_word(input logic [3:0] c, input logic [15:0] low);
        return {c, 12'h000, low};
    endfunction

    typedef struct {
        string       name;
        bit          s;
        logic [31:0] g;
        bit          r;
        bit          ev;
        int          et, er, ep, ec;
        logic [31:0] ed;
        logic [31:0] es;
    } vec_t;

    function automatic vec_t mkv(input string name, input bit s, input logic [31:0] g, input bit r,
                                 input bit ev, input int et, input int er, input int ep, input int ec,
                                 input logic [31:0] ed, input logic [31:0] es);
        vec_t v;
        v.name = name; v.s = s; v.g = g; v.r = r; v.ev = ev;
        v.et = et; v.er = er; v.ep = ep; v.ec = ec; v.ed = ed; v.es = es;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        vt[0]  = mkv("reset_idle",     0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[1]  = mkv("latch_addr",     1, addr_word(3, 1, 5, 0), 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[2]  = mkv("latch_chunk",    1, cmd_word(CMD_LATCH_CHUNK, 16'hDEAD), 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[3]  = mkv("write_matrix",   1, cmd_word(CMD_WRITE_MATRIX, 16'hBEEF), 1, 1, 0, 3, 1, 5, 32'hDEAD_BEEF, 32'h0000_1000);
        vt[4]  = mkv("popped",         0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[5]  = mkv("undef_f",        1, 32'hF123_4567, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[6]  = mkv("undef_0",        1, 32'h0000_FFFF, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0400);
        vt[7]  = mkv("latch_autoinc",  1, addr_word(31, 1, 511, 1), 0, 0, 0, 0, 0, 0, 32'h0, 32'h0001_0400);
        vt[8]  = mkv("wrap_push_a",    1, cmd_word(CMD_WRITE_MATRIX, 16'h0001), 0, 1, 0, 31, 1, 511, 32'hDEAD_0001, 32'h0001_1000);
        vt[9]  = mkv("wrap_push_b",    1, cmd_word(CMD_WRITE_MATRIX, 16'h0002), 0, 1, 0, 31, 1, 511, 32'hDEAD_0001, 32'h0001_2000);
        vt[10] = mkv("wrap_pop_a",     0, 32'h0, 1, 1, 0, 0, 0, 0, 32'hDEAD_0002, 32'h0001_1000);
        vt[11] = mkv("wrap_pop_b",     0, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0001_0400);
        vt[12] = mkv("no_strobe",      0, cmd_word(CMD_WRITE_MATRIX, 16'h1234), 1, 0, 0, 0, 0, 0, 32'h0, 32'h0001_0400);

        model_reset();
        repeat (2) @(negedge clk);
        check("in_reset status", 64'(status), 64'h400);
        check("in_reset valid", 64'(wr_valid), 64'h0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            tick(vt[i].s, vt[i].g, vt[i].r);
            check({vt[i].name, " status"}, 64'(status), 64'(vt[i].es));
            check({vt[i].name, " valid"}, 64'(wr_valid), 64'(vt[i].ev));
            if (vt[i].ev) begin
                check({vt[i].name, " target"}, 64'(wr_target), 64'(vt[i].et));
                check({vt[i].name, " row"},    64'(wr_row),    64'(vt[i].er));
                check({vt[i].name, " plane"},  64'(wr_plane),  64'(vt[i].ep));
                check({vt[i].name, " column"}, 64'(wr_column), 64'(vt[i].ec));
                check({vt[i].name, " data"},   64'(wr_data),   64'(vt[i].ed));
            end
        end

        // Overflow: six matrix writes into a stalled depth-4 queue
        tick(1, addr_word(2, 0, 10, 1), 0);
        for (int i = 0; i < 6; i++) tick(1, cmd_word(CMD_WRITE_MATRIX, 16'(16'h0010 + i)), 0);
        check("ovf status", 64'(status), 64'h0001_4902);
        check("ovf head col", 64'(wr_column), 64'd10);
        check("ovf head data", 64'(wr_data), 64'hDEAD_0010);
        tick(1, cmd_word(CMD_CLEAR_STATUS, 16'h0), 0);
        check("clear status", 64'(status), 64'h0001_4800);

        // Full queue, pop and push in the same cycle
        tick(1, cmd_word(CMD_WRITE_GAIN, 16'h00AA), 1);
        check("full_pushpop status", 64'(status), 64'h0001_4800);
        check("full_pushpop head col", 64'(wr_column), 64'd11);
        repeat (3) tick(0, 32'h0, 1);
        check("gain entry target", 64'(wr_target), 64'(TGT_GAIN));
        check("gain entry col", 64'(wr_column), 64'd14);
        check("gain entry data", 64'(wr_data), 64'hDEAD_00AA);
        tick(0, 32'h0, 1);
        tick(1, cmd_word(CMD_WRITE_MATRIX, 16'h0055), 0);
        check("after_four_incr col", 64'(wr_column), 64'd14);
        tick(0, 32'h0, 1);

        // Rejected address keeps the previous one
        tick(1, addr_word(1, 2, 3, 0), 0);
        check("addr_err status", 64'(status), 64'h0001_0600);
        tick(1, cmd_word(CMD_WRITE_FFB_CLIP, 16'h0077), 0);
        check("addr_err head target", 64'(wr_target), 64'(TGT_FFB_CLIP));
        check("addr_err head row", 64'(wr_row), 64'd2);
        check("addr_err head plane", 64'(wr_plane), 64'd0);
        check("addr_err head col", 64'(wr_column), 64'd15);
        tick(0, 32'h0, 1);

        // Drop counter saturation
        tick(1, cmd_word(CMD_CLEAR_STATUS, 16'h0), 0);
        for (int i = 0; i < 260; i++) tick(1, cmd_word(CMD_WRITE_GAIN, 16'(i)), 0);
        check("drop_sat status", 64'(status), 64'h0001_49FF);

        // Random traffic against the model
        tick(1, cmd_word(CMD_CLEAR_STATUS, 16'h0), 1);
        compare_model("rnd_start");
        for (int i = 0; i < 600; i++) begin
            logic [31:0] g;
            bit s, r;
            g = $urandom;
            g[31:28] = 4'($urandom_range(0, 15));
            if (g[31:28] == 4'h1 && $urandom_range(0, 7) != 0) begin
                g[16] = 1'b0;
                g[10] = 1'b0;
            end
            s = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            tick(s, g, r);
            compare_model("rnd");
        end

        // Reset with entries queued
        repeat (6) tick(0, 32'h0, 1);
        for (int i = 0; i < 3; i++) tick(1, cmd_word(CMD_WRITE_PS_OFFSET, 16'(i)), 0);
        check("pre_rst valid", 64'(wr_valid), 64'h1);
        check("pre_rst occupancy", 64'(status[15:12]), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst valid", 64'(wr_valid), 64'h0);
        check("async_rst status", 64'(status), 64'h0000_0400);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(0, 32'h0, 1);
        compare_model("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fofb_coef_write_engine.md
Name: fofb_coef_write_engine

Overview:
- Parametrised successor to the FOFB DSP CSR front end.
- Decodes GPIO command strobes into coefficient/config writes for the matrix multiplier, FIR and power-supply setpoint stages.
- Generalised: coefficient width (multi-chunk assembly), plane count, optional address auto-increment, and a queued valid/ready write port with drop accounting. Replaces direct single-cycle write strobes.

Parameters:
- RESULT_COUNT, 32, matrix rows (correctors); ROW_W = max(1, clog2(RESULT_COUNT)).
- PLANE_COUNT, 2, planes (0=X, 1=Y, 2=S...); PLANE_W = max(1, clog2(PLANE_COUNT)).
- MATRIX_ADDR_WIDTH, 9, column (BPM) index width.
- COEFFICIENT_WIDTH, 32, data width; multiple of 16, >=16; CHUNKS = COEFFICIENT_WIDTH/16.
- CMD_SHIFT, 28, LSB of the 4-bit command field in GPIO_OUT.
- FIFO_DEPTH, 4, write-queue entries; power of two, >=2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- csrStrobe, input, 1, one-cycle GPIO command qualifier.
- GPIO_OUT, input, 32, command word; cmd = GPIO_OUT[CMD_SHIFT+:4].
- status, output, 32, status/diagnostics.
- wr_valid, output, 1, queue head valid.
- wr_ready, input, 1, consumer accepts head.
- wr_target, output, 3, destination code (package enum).
- wr_row, output, ROW_W, row.
- wr_plane, output, PLANE_W, plane.
- wr_column, output, MATRIX_ADDR_WIDTH, column.
- wr_data, output, COEFFICIENT_WIDTH, assembled value.

Behaviour:
- Reset (async assert, sync release): row/plane/column = 0, chunk register = 0, autoinc = 0, queue empty, wr_valid = 0, status = 0 except EMPTY = 1.
- Commands act only on csrStrobe. Undefined codes are ignored with no state change.
- LATCH_ADDRESS: column = GPIO_OUT[0+:MATRIX_ADDR_WIDTH]; plane and row from the following fields; autoinc = GPIO_OUT[CMD_SHIFT-1].
  - Plane >= PLANE_COUNT or row >= RESULT_COUNT: the address is not latched and ADDR_ERR (sticky) is set.
- LATCH_CHUNK: chunk shift register (CHUNKS-1 x 16 bits) shifts left by 16, GPIO_OUT[15:0] enters the low chunk. No effect when CHUNKS == 1.
- Write commands (MATRIX, GAIN, FFB_CLIP, PS_OFFSET, PS_CLIP, FIR_RELOAD, FIR_CONFIG):
  - Push {target, row, plane, column, {chunks, GPIO_OUT[15:0]}}.
  - The chunk register is not cleared after a push.
- Auto-increment applies only to accepted MATRIX pushes with autoinc = 1. On the cycle after the push:
  - column + 1, wrapping at 2^MATRIX_ADDR_WIDTH-1 to 0.
  - On column wrap, plane + 1, wrapping at PLANE_COUNT-1 to 0.
  - On plane wrap, row + 1, wrapping at RESULT_COUNT-1 to 0.
- Queue is first-word-fall-through.
  - Strobe in cycle N into an empty queue gives wr_valid = 1 in N+1.
  - Head outputs are held stable while wr_valid && !wr_ready.
  - Pop when wr_valid && wr_ready.
- Full queue: a push is accepted if a pop occurs in the same cycle. Otherwise the push is dropped:
  - OVERFLOW (sticky) is set.
  - DROP_COUNT increments, saturating at 255.
  - Auto-increment does not advance.
- Simultaneous push and pop on an empty queue: the push is accepted; the entry appears the next cycle. No bypass.
- CLEAR_STATUS clears OVERFLOW, ADDR_ERR and DROP_COUNT only. The queue is untouched.
- Status bits:
  - [7:0] DROP_COUNT, [8] OVERFLOW, [9] ADDR_ERR, [10] EMPTY, [11] FULL.
  - [15:12] occupancy, saturating at 15.
  - [16] autoinc.
  - [31:17] = 0.
- Reset mid-operation discards all queued entries; wr_valid drops asynchronously.

Decomposition:
- Package fofb_coef_pkg:
  - 4-bit command codes: LATCH_ADDRESS, LATCH_CHUNK, WRITE_MATRIX, WRITE_GAIN, WRITE_FFB_CLIP, WRITE_PS_OFFSET, WRITE_PS_CLIP, FIR_RELOAD, FIR_CONFIG, CLEAR_STATUS.
  - 3-bit target enum.
  - Status bit indices.
- Sub-module fofb_cmd_fifo: generic FWFT synchronous FIFO (WIDTH, DEPTH) with full/empty/count and async rst.

Test Plan:
- Reset, then LATCH_ADDRESS col=5 plane=1 row=3, LATCH_CHUNK 0xDEAD, WRITE_MATRIX low=0xBEEF with wr_ready=1 -> one cycle of wr_valid with target=MATRIX, row 3, plane 1, col 5, data 0xDEADBEEF; EMPTY returns to 1.
- Autoinc=1, col=511 plane=1 row=31, two WRITE_MATRIX -> entries (31,1,511) then (0,0,0).
- wr_ready=0, six writes, FIFO_DEPTH=4 -> FULL=1, DROP_COUNT=2, OVERFLOW=1, auto-increment advanced 4 times only; CLEAR_STATUS -> count 0, queue still 4.
- Full queue with wr_ready=1 and a same-cycle WRITE_GAIN -> accepted, DROP_COUNT unchanged, occupancy stays 4.
- LATCH_ADDRESS plane=2 (PLANE_COUNT=2) -> ADDR_ERR=1, previous address retained in the next write.
- rst asserted with 3 entries queued while wr_valid=1 -> wr_valid=0 immediately, EMPTY=1, status otherwise 0.
